// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with a start/busy/done handshake.
// Optional feature macro: MUL_ZERO_SKIP_EN (zero operand bypasses the RUN phase).
module shift_add_multiplier #(
  parameter int bits = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [bits-1:0]     A,
  input  logic [bits-1:0]     B,
  output logic                busy,
  output logic                done,
  output logic [2*bits-1:0]   P
);

  localparam int CW = (bits > 1) ? $clog2(bits) : 1;

  // Handshake: start is accepted on a rising edge only while idle or done;
  // busy is high exactly in RUN; done pulses for one cycle with P valid and
  // P then holds until the next result. done and busy are never high together.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    SKIP = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [bits-1:0] mcand;
  logic [bits-1:0] mplier;
  logic [bits:0]   acc;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            last;
  logic            zero_ops;
  logic [bits:0]   sum;
  logic [bits:0]   acc_nxt;
  logic [bits-1:0] mplier_nxt;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(bits - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

`ifdef MUL_ZERO_SKIP_EN
  assign zero_ops = (A == '0) || (B == '0);
`else
  assign zero_ops = 1'b0;
`endif

  // acc[bits] is always zero after a shift, so adding the full acc equals
  // adding acc[bits-1:0]; the carry lands in sum[bits].
  assign sum        = acc + {1'b0, (mplier[0] ? mcand : {bits{1'b0}})};
  assign acc_nxt    = {1'b0, sum[bits:1]};
  assign mplier_nxt = {sum[0], mplier[bits-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_ops ? SKIP : RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE: begin
        if (start) state_nxt = zero_ops ? SKIP : RUN;
        else       state_nxt = IDLE;
      end
      SKIP: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
    end else if (accept) begin
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt + CW'(1);
      if (last) P <= {acc_nxt[bits-1:0], mplier_nxt};
    end else if (state == SKIP) begin
      P <= '0;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (bits=4 and bits=8 instances).
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  A4, B4;
  logic [7:0]  A8, B8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  P4;
  logic [15:0] P8;

  logic [7:0]  exp_q[$];
  logic [15:0] exp8_q[$];

  int total;
  int bad;

  shift_add_multiplier #(.bits(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4),
    .busy(busy4), .done(done4), .P(P4)
  );

  shift_add_multiplier #(.bits(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .P(P8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT  = 1;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 4;
  localparam int ZERO_BUSY = 4;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: present operands with start for one edge and record the expected product
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] prod;
    prod = {4'b0, a} * {4'b0, b};
    A4 = a;
    B4 = b;
    start4 = 1'b1;
    exp_q.push_back(prod);
    tick;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int n;
    int bc;
    bit seen;
    bit overlap;
    logic [7:0] e;
    n = 0; bc = 0; seen = 0; overlap = 0;
    while (!seen && n < 40) begin
      if (busy4) bc++;
      tick;
      n++;
      if (done4 && busy4) overlap = 1;
      if (done4) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: done never seen after %0d cycles", name, n);
    end
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    total++;
    if (P4 !== e) begin
      bad++;
      $display("FAIL %s_product: got %0d want %0d", name, P4, e);
    end
    total++;
    if (n != exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, n, exp_lat);
    end
    total++;
    if (bc != exp_busy) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, exp_busy);
    end
    total++;
    if (overlap !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_done_overlap: got %0b want 0", name, overlap);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy4, done4);
    end
    total++;
    if (P4 !== 8'd0) begin
      bad++;
      $display("FAIL reset_p4: got %0d want 0", P4);
    end
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || P8 !== 16'd0) begin
      bad++;
      $display("FAIL reset_dut8: got busy=%b done=%b P=%0d want 0 0 0", busy8, done8, P8);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    start_op(4'd3, 4'd5);
    wait_done("mul_3x5", 4, 4);
    tick;
    total++;
    if (done4 !== 1'b0 || P4 !== 8'd15) begin
      bad++;
      $display("FAIL done_pulse_hold: got done=%b P=%0d want 0 15", done4, P4);
    end
    start_op(4'd15, 4'd15);
    wait_done("mul_15x15", 4, 4);
    tick;
  endtask

  task automatic test_zero;
    start_op(4'd0, 4'd9);
    wait_done("mul_0x9", ZERO_LAT, ZERO_BUSY);
    tick;
    start_op(4'd5, 4'd0);
    wait_done("mul_5x0", ZERO_LAT, ZERO_BUSY);
    tick;
  endtask

  task automatic test_ignore_start;
    start_op(4'd7, 4'd6);
    tick;
    A4 = 4'd1;
    B4 = 4'd1;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    A4 = 4'd2;
    B4 = 4'd3;
    wait_done("ignore_mid_run", 2, 2);
    tick;
    total++;
    if (busy4 !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_restart: got busy=%b want 0", busy4);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] old_p;
    start_op(4'd11, 4'd13);
    wait_done("b2b_first", 4, 4);
    old_p = 8'd143;
    start_op(4'd6, 4'd9);
    total++;
    if (P4 !== old_p || busy4 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept_hold: got P=%0d busy=%b want %0d 1", P4, busy4, old_p);
    end
    wait_done("b2b_second", 4, 4);
    tick;
  endtask

  task automatic test_abort;
    bit done_seen;
    start_op(4'd9, 4'd9);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || P4 !== 8'd0) begin
      bad++;
      $display("FAIL abort_reset: got busy=%b done=%b P=%0d want 0 0 0", busy4, done4, P4);
    end
    tick;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done4 || busy4) done_seen = 1;
    end
    total++;
    if (done_seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got activity=%b want 0", done_seen);
    end
  endtask

  task automatic test_random;
    logic [3:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(1, 15));
      b = 4'($urandom_range(1, 15));
      start_op(a, b);
      wait_done("random", 4, 4);
      tick;
    end
  endtask

  task automatic test_held_start_8;
    int n;
    int last_n;
    int got;
    bit overlap;
    logic [15:0] e;
    for (int i = 0; i < 3; i++) exp8_q.push_back(16'd65025);
    A8 = 8'd255;
    B8 = 8'd255;
    start8 = 1'b1;
    tick;
    n = 0; last_n = 0; got = 0; overlap = 0;
    while (got < 3 && n < 60) begin
      tick;
      n++;
      if (done8 && busy8) overlap = 1;
      if (done8) begin
        e = exp8_q.pop_front();
        total++;
        if (P8 !== e) begin
          bad++;
          $display("FAIL held8_product: got %0d want %0d", P8, e);
        end
        total++;
        if ((n - last_n) != ((got == 0) ? 8 : 9)) begin
          bad++;
          $display("FAIL held8_interval: got %0d want %0d", n - last_n, (got == 0) ? 8 : 9);
        end
        last_n = n;
        got++;
      end
    end
    start8 = 1'b0;
    total++;
    if (got != 3) begin
      bad++;
      $display("FAIL held8_count: got %0d want 3", got);
    end
    total++;
    if (overlap !== 1'b0) begin
      bad++;
      $display("FAIL held8_overlap: got %0b want 0", overlap);
    end
    tick;
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || P8 !== 16'd65025) begin
      bad++;
      $display("FAIL held8_idle: got busy=%b done=%b P=%0d want 0 0 65025", busy8, done8, P8);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    A4 = '0; B4 = '0;
    A8 = '0; B8 = '0;
    test_reset;
    test_basic;
    test_zero;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    test_random;
    test_held_start_8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
